// File: rtl/memory_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage_pkg
// Description : Shared widths, bus field offsets, load-type encodings and
//               exception codes for the M (memory) pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_stage_pkg;

    // Bus widths
    localparam int EM_BUS_W  = 294;
    localparam int MW_BUS_W  = 262;
    localparam int FWD_BUS_W = 121;

    // EM_BUS field LSB positions (MSB-first layout). The lower MW_BUS_W bits
    // of EM_BUS share the exact layout of MW_BUS; only rdata sits above them.
    localparam int EM_CSR_WDATA_LSB = 0;
    localparam int EM_CSR_WMASK_LSB = 32;
    localparam int EM_CSR_WE_BIT    = 64;
    localparam int EM_CSR_ADDR_LSB  = 65;
    localparam int EM_ESUBCODE_BIT  = 79;
    localparam int EM_ECODE_LSB     = 80;
    localparam int EM_EX_BIT        = 88;
    localparam int EM_VADDR_LSB     = 89;
    localparam int EM_RFM_LSB       = 121;
    localparam int EM_DEST_LSB      = 125;
    localparam int EM_GR_WE_BIT     = 130;
    localparam int EM_RF_WDATA_LSB  = 131;
    localparam int EM_PC_LSB        = 163;
    localparam int EM_PB_LSB        = 195;
    localparam int EM_RDATA_LSB     = 262;

    // res_from_mem encodings: bit2 selects zero extension, bits[1:0] size
    localparam logic [3:0] LD_NONE = 4'b0000;
    localparam logic [3:0] LD_B    = 4'b0001;
    localparam logic [3:0] LD_BU   = 4'b0101;
    localparam logic [3:0] LD_H    = 4'b0011;
    localparam logic [3:0] LD_HU   = 4'b0111;
    localparam logic [3:0] LD_W    = 4'b1111;

    // Exception codes carried through the pipeline
    localparam logic [7:0] ECODE_INT = 8'h00;
    localparam logic [7:0] ECODE_PIL = 8'h01;
    localparam logic [7:0] ECODE_PIS = 8'h02;
    localparam logic [7:0] ECODE_PIF = 8'h03;
    localparam logic [7:0] ECODE_PME = 8'h04;
    localparam logic [7:0] ECODE_PPI = 8'h07;
    localparam logic [7:0] ECODE_ADE = 8'h08;
    localparam logic [7:0] ECODE_ALE = 8'h09;
    localparam logic [7:0] ECODE_SYS = 8'h0B;
    localparam logic [7:0] ECODE_BRK = 8'h0C;
    localparam logic [7:0] ECODE_INE = 8'h0D;
    localparam logic [7:0] ECODE_IPE = 8'h0E;

endpackage : memory_stage_pkg
`default_nettype wire

// File: rtl/memory_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Selects the byte/half lane of a raw load word by the low
//               address bits and sign- or zero-extends it to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import memory_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [3:0]  ld_type,
    output logic [31:0] value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte lane pick by the full low address
    always_comb begin
        w_byte = rdata[7:0];
        case (addr_lo)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
    end

    // Halfword lane only looks at addr_lo[1]; misaligned halves trap earlier
    assign w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Extension according to load type; unknown types produce zero
    always_comb begin
        value = 32'h0000_0000;
        case (ld_type)
            LD_B:    value = {{24{w_byte[7]}}, w_byte};
            LD_BU:   value = {24'h000000, w_byte};
            LD_H:    value = {{16{w_half[15]}}, w_half};
            LD_HU:   value = {16'h0000, w_half};
            LD_W:    value = rdata;
            default: value = 32'h0000_0000;
        endcase
    end

endmodule : load_align
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage
// Description : M stage of the 5-stage pipeline. Registers the E->M bundle,
//               aligns load data, forwards the final result to D and carries
//               exception/CSR fields to W. Squashes on flush and after a
//               faulting bundle until the flush arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int EM_W  = EM_BUS_W,
    parameter int MW_W  = MW_BUS_W,
    parameter int FWD_W = FWD_BUS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EM_valid,
    input  logic [EM_W-1:0]  EM_BUS,
    output logic             M_allowin,
    input  logic             W_allowin,
    output logic             MW_valid,
    output logic [MW_W-1:0]  MW_BUS,
    output logic [FWD_W-1:0] MD_for_BUS,
    output logic             ex_M,
    input  logic             ex_en
);

    logic            r_m_valid;
    logic [EM_W-1:0] r_bundle;
    logic            r_ex_flag;

    logic            w_accept;
    logic            w_gr_we;
    logic            w_is_load;
    logic [31:0]     w_load_value;
    logic [31:0]     w_rf_wdata_m;
    logic [4:0]      w_dest;
    logic [3:0]      w_rfm;

    // No multi-cycle work in M, so readiness depends only on W
    assign M_allowin = ~r_m_valid | W_allowin;
    assign MW_valid  = r_m_valid;
    assign ex_M      = r_m_valid & r_bundle[EM_EX_BIT];

    // A new bundle is taken only when no exception is in flight
    assign w_accept  = EM_valid & M_allowin & ~r_ex_flag & ~ex_M;

    // Pipeline register: flush beats capture, dropped bundles leave it untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_bundle  <= '0;
        end else if (ex_en) begin
            r_m_valid <= 1'b0;
            r_bundle  <= '0;
        end else if (M_allowin) begin
            r_m_valid <= w_accept;
            if (w_accept) begin
                r_bundle <= EM_BUS;
            end
        end
    end

    // Exception shadow: blocks younger bundles until W commits the flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_flag <= 1'b0;
        end else if (ex_en) begin
            r_ex_flag <= 1'b0;
        end else if (ex_M) begin
            r_ex_flag <= 1'b1;
        end
    end

    assign w_rfm     = r_bundle[EM_RFM_LSB +: 4];
    assign w_dest    = r_bundle[EM_DEST_LSB +: 5];
    assign w_is_load = |w_rfm;

    load_align u_load_align (
        .rdata   (r_bundle[EM_RDATA_LSB +: 32]),
        .addr_lo (r_bundle[EM_VADDR_LSB +: 2]),
        .ld_type (w_rfm),
        .value   (w_load_value)
    );

    // A faulting bundle never writes the GPR and ignores load data
    assign w_gr_we      = r_bundle[EM_GR_WE_BIT] & ~ex_M;
    assign w_rf_wdata_m = (w_is_load & ~ex_M) ? w_load_value
                                              : r_bundle[EM_RF_WDATA_LSB +: 32];

    assign MW_BUS = {r_bundle[EM_PB_LSB + 66 : EM_PC_LSB],
                     w_rf_wdata_m,
                     w_gr_we,
                     r_bundle[EM_GR_WE_BIT - 1 : 0]};

    // Forwarding: data is already final here, the top 4 bits are reserved zero
    assign MD_for_BUS = {4'b0000,
                         r_m_valid & w_is_load,
                         w_dest & {5{r_m_valid & w_gr_we}},
                         w_rf_wdata_m,
                         r_bundle[EM_CSR_WE_BIT] & r_m_valid,
                         r_bundle[EM_CSR_ADDR_LSB +: 14],
                         r_bundle[EM_CSR_WMASK_LSB +: 32],
                         r_bundle[EM_CSR_WDATA_LSB +: 32]};

endmodule : memory_stage
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_stage
// Description : Directed self-checking bench for memory_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_stage;

    logic         clk;
    logic         rst;
    logic         EM_valid;
    logic [293:0] EM_BUS;
    logic         M_allowin;
    logic         W_allowin;
    logic         MW_valid;
    logic [261:0] MW_BUS;
    logic [120:0] MD_for_BUS;
    logic         ex_M;
    logic         ex_en;

    int n_cmp;
    int n_err;

    localparam logic [66:0] C_PB      = 67'h4_DEAD_BEEF_CAFE_F00D;
    localparam logic [31:0] C_PC      = 32'h1C00_0100;
    localparam logic [13:0] C_CSRADDR = 14'h0105;
    localparam logic [31:0] C_WMASK   = 32'hFFFF_0000;
    localparam logic [31:0] C_WDATA   = 32'h1234_5678;

    memory_stage dut (
        .clk        (clk),
        .rst        (rst),
        .EM_valid   (EM_valid),
        .EM_BUS     (EM_BUS),
        .M_allowin  (M_allowin),
        .W_allowin  (W_allowin),
        .MW_valid   (MW_valid),
        .MW_BUS     (MW_BUS),
        .MD_for_BUS (MD_for_BUS),
        .ex_M       (ex_M),
        .ex_en      (ex_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [261:0] build_mw(input logic [31:0] rfw, input logic gr_we,
                                              input logic [4:0] dest, input logic [3:0] rfm,
                                              input logic [31:0] vaddr, input logic ex,
                                              input logic [7:0] ecode, input logic csr_we);
        return {C_PB, C_PC, rfw, gr_we, dest, rfm, vaddr, ex, ecode, 1'b0,
                C_CSRADDR, csr_we, C_WMASK, C_WDATA};
    endfunction

    function automatic logic [293:0] build_em(input logic [31:0] rdata, input logic [31:0] rfw,
                                              input logic gr_we, input logic [4:0] dest,
                                              input logic [3:0] rfm, input logic [31:0] vaddr,
                                              input logic ex, input logic [7:0] ecode,
                                              input logic csr_we);
        return {rdata, build_mw(rfw, gr_we, dest, rfm, vaddr, ex, ecode, csr_we)};
    endfunction

    task automatic test_reset();
        rst = 1'b1; EM_valid = 1'b0; EM_BUS = '0; W_allowin = 1'b1; ex_en = 1'b0;
        #12;
        n_cmp++; if (MW_valid !== 1'b0) begin n_err++; $display("FAIL reset_mw_valid got %b want 0", MW_valid); end
        n_cmp++; if (ex_M !== 1'b0) begin n_err++; $display("FAIL reset_ex_M got %b want 0", ex_M); end
        n_cmp++; if (M_allowin !== 1'b1) begin n_err++; $display("FAIL reset_allowin got %b want 1", M_allowin); end
        n_cmp++; if (MD_for_BUS !== 121'h0) begin n_err++; $display("FAIL reset_md got %h want 0", MD_for_BUS); end
        n_cmp++; if (MW_BUS !== 262'h0) begin n_err++; $display("FAIL reset_mw_bus got %h want 0", MW_BUS); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load_align();
        logic [31:0] rd  [8];
        logic [1:0]  lo  [8];
        logic [3:0]  ty  [8];
        logic [31:0] exv [8];
        logic [31:0] va;
        logic [31:0] rfe;
        rd[0] = 32'h80FF_1234; lo[0] = 2'd3; ty[0] = 4'b0001; exv[0] = 32'hFFFF_FF80;
        rd[1] = 32'h80FF_1234; lo[1] = 2'd3; ty[1] = 4'b0101; exv[1] = 32'h0000_0080;
        rd[2] = 32'h8001_7FFF; lo[2] = 2'd2; ty[2] = 4'b0011; exv[2] = 32'hFFFF_8001;
        rd[3] = 32'h8001_7FFF; lo[3] = 2'd2; ty[3] = 4'b0111; exv[3] = 32'h0000_8001;
        rd[4] = 32'h8001_7FFF; lo[4] = 2'd0; ty[4] = 4'b1111; exv[4] = 32'h8001_7FFF;
        rd[5] = 32'h80FF_1234; lo[5] = 2'd1; ty[5] = 4'b0001; exv[5] = 32'h0000_0012;
        rd[6] = 32'h8001_7FFF; lo[6] = 2'd0; ty[6] = 4'b0011; exv[6] = 32'h0000_7FFF;
        rd[7] = 32'hFFFF_FFFF; lo[7] = 2'd1; ty[7] = 4'b0000; exv[7] = 32'hA5A5_0007;
        for (int i = 0; i < 8; i++) begin
            va  = 32'h0000_1000 | {30'h0, lo[i]};
            rfe = 32'hA5A5_0000 + i;
            EM_valid = 1'b1;
            EM_BUS   = build_em(rd[i], rfe, 1'b1, 5'd4, ty[i], va, 1'b0, 8'h00, i[0]);
            @(posedge clk); #1;
            EM_valid = 1'b0;
            n_cmp++; if (MW_valid !== 1'b1) begin n_err++; $display("FAIL load%0d_valid got %b want 1", i, MW_valid); end
            n_cmp++; if (MW_BUS !== build_mw(exv[i], 1'b1, 5'd4, ty[i], va, 1'b0, 8'h00, i[0])) begin
                n_err++; $display("FAIL load%0d_mw_bus rf_wdata got %h want %h", i, MW_BUS[162:131], exv[i]);
            end
            n_cmp++; if (MD_for_BUS[116] !== (ty[i] != 4'b0000)) begin n_err++; $display("FAIL load%0d_ld_pending got %b", i, MD_for_BUS[116]); end
            n_cmp++; if (MD_for_BUS !== {4'b0, (ty[i] != 4'b0000), 5'd4, exv[i], i[0], C_CSRADDR, C_WMASK, C_WDATA}) begin
                n_err++; $display("FAIL load%0d_md got %h", i, MD_for_BUS);
            end
        end
        @(posedge clk); #1;
        n_cmp++; if (MW_valid !== 1'b0) begin n_err++; $display("FAIL load_drain_valid got %b want 0", MW_valid); end
        n_cmp++; if (MD_for_BUS[115:111] !== 5'd0) begin n_err++; $display("FAIL load_drain_dest got %h want 0", MD_for_BUS[115:111]); end
    endtask

    task automatic test_stall();
        logic [261:0] exp_a;
        W_allowin = 1'b1;
        EM_valid  = 1'b1;
        EM_BUS    = build_em(32'h0, 32'h1111_1111, 1'b1, 5'd3, 4'b0000, 32'h2000, 1'b0, 8'h00, 1'b0);
        exp_a     = build_mw(32'h1111_1111, 1'b1, 5'd3, 4'b0000, 32'h2000, 1'b0, 8'h00, 1'b0);
        @(posedge clk); #1;
        W_allowin = 1'b0;
        EM_BUS    = build_em(32'h0, 32'h2222_2222, 1'b1, 5'd6, 4'b0000, 32'h2004, 1'b0, 8'h00, 1'b0);
        #1;
        n_cmp++; if (M_allowin !== 1'b0) begin n_err++; $display("FAIL stall_allowin got %b want 0", M_allowin); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_cmp++; if (MW_valid !== 1'b1) begin n_err++; $display("FAIL stall%0d_valid got %b want 1", k, MW_valid); end
            n_cmp++; if (MW_BUS !== exp_a) begin n_err++; $display("FAIL stall%0d_bus got %h want %h", k, MW_BUS[162:131], 32'h1111_1111); end
            n_cmp++; if (M_allowin !== 1'b0) begin n_err++; $display("FAIL stall%0d_allowin got %b want 0", k, M_allowin); end
            n_cmp++; if (MD_for_BUS[115:79] !== {5'd3, 32'h1111_1111}) begin n_err++; $display("FAIL stall%0d_md got %h", k, MD_for_BUS[115:79]); end
        end
        W_allowin = 1'b1;
        #1;
        n_cmp++; if (M_allowin !== 1'b1) begin n_err++; $display("FAIL release_allowin got %b want 1", M_allowin); end
        @(posedge clk); #1;
        EM_valid = 1'b0;
        n_cmp++; if (MW_BUS[162:131] !== 32'h2222_2222) begin n_err++; $display("FAIL release_capture got %h want 22222222", MW_BUS[162:131]); end
        n_cmp++; if (MW_valid !== 1'b1) begin n_err++; $display("FAIL release_valid got %b want 1", MW_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_exception();
        W_allowin = 1'b1;
        EM_valid  = 1'b1;
        EM_BUS    = build_em(32'hFFFF_FFFF, 32'h3333_3333, 1'b1, 5'd7, 4'b1111, 32'h1001, 1'b1, 8'h09, 1'b0);
        @(posedge clk); #1;
        EM_BUS    = build_em(32'h0, 32'h4444_4444, 1'b1, 5'd8, 4'b0000, 32'h3000, 1'b0, 8'h00, 1'b0);
        n_cmp++; if (ex_M !== 1'b1) begin n_err++; $display("FAIL ex_flagged got %b want 1", ex_M); end
        n_cmp++; if (MW_BUS[130] !== 1'b0) begin n_err++; $display("FAIL ex_mw_gr_we got %b want 0", MW_BUS[130]); end
        n_cmp++; if (MD_for_BUS[115:111] !== 5'd0) begin n_err++; $display("FAIL ex_md_dest got %h want 0", MD_for_BUS[115:111]); end
        n_cmp++; if (MW_BUS[88:80] !== 9'h109) begin n_err++; $display("FAIL ex_ecode got %h want 109", MW_BUS[88:80]); end
        n_cmp++; if (MW_BUS[162:131] !== 32'h3333_3333) begin n_err++; $display("FAIL ex_rf_wdata got %h want 33333333", MW_BUS[162:131]); end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            n_cmp++; if (MW_valid !== 1'b0) begin n_err++; $display("FAIL ex_drop%0d_valid got %b want 0", k, MW_valid); end
            n_cmp++; if (ex_M !== 1'b0) begin n_err++; $display("FAIL ex_drop%0d_ex_M got %b want 0", k, ex_M); end
        end
        ex_en = 1'b1;
        @(posedge clk); #1;
        ex_en  = 1'b0;
        EM_BUS = build_em(32'h0, 32'h5555_5555, 1'b1, 5'd9, 4'b0000, 32'h3004, 1'b0, 8'h00, 1'b0);
        n_cmp++; if (MW_valid !== 1'b0) begin n_err++; $display("FAIL ex_flush_valid got %b want 0", MW_valid); end
        @(posedge clk); #1;
        EM_valid = 1'b0;
        n_cmp++; if (MW_valid !== 1'b1) begin n_err++; $display("FAIL ex_resume_valid got %b want 1", MW_valid); end
        n_cmp++; if (MW_BUS[162:131] !== 32'h5555_5555) begin n_err++; $display("FAIL ex_resume_data got %h want 55555555", MW_BUS[162:131]); end
        n_cmp++; if (MD_for_BUS[115:111] !== 5'd9) begin n_err++; $display("FAIL ex_resume_dest got %h want 9", MD_for_BUS[115:111]); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush_capture();
        W_allowin = 1'b1;
        EM_valid  = 1'b1;
        ex_en     = 1'b1;
        EM_BUS    = build_em(32'h0, 32'h6666_6666, 1'b1, 5'd10, 4'b0000, 32'h4000, 1'b0, 8'h00, 1'b1);
        @(posedge clk); #1;
        EM_valid = 1'b0;
        ex_en    = 1'b0;
        n_cmp++; if (MW_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", MW_valid); end
        n_cmp++; if (MW_BUS !== 262'h0) begin n_err++; $display("FAIL flush_bus got %h want 0", MW_BUS[162:131]); end
        n_cmp++; if (MD_for_BUS[78] !== 1'b0) begin n_err++; $display("FAIL flush_csr_we got %b want 0", MD_for_BUS[78]); end
        @(posedge clk); #1;
    endtask

    task automatic test_async_rst();
        W_allowin = 1'b1;
        EM_valid  = 1'b1;
        EM_BUS    = build_em(32'h0, 32'h7777_7777, 1'b1, 5'd11, 4'b0000, 32'h5000, 1'b0, 8'h00, 1'b1);
        @(posedge clk); #1;
        EM_valid = 1'b0;
        n_cmp++; if (MW_valid !== 1'b1) begin n_err++; $display("FAIL arst_pre_valid got %b want 1", MW_valid); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (MW_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got %b want 0", MW_valid); end
        n_cmp++; if (MD_for_BUS !== 121'h0) begin n_err++; $display("FAIL arst_md got %h want 0", MD_for_BUS); end
        n_cmp++; if (MW_BUS !== 262'h0) begin n_err++; $display("FAIL arst_bus got %h want 0", MW_BUS[162:131]); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (MW_valid !== 1'b0) begin n_err++; $display("FAIL arst_after_valid got %b want 0", MW_valid); end
        n_cmp++; if (M_allowin !== 1'b1) begin n_err++; $display("FAIL arst_after_allowin got %b want 1", M_allowin); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_load_align();
        test_stall();
        test_exception();
        test_flush_capture();
        test_async_rst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_memory_stage
`default_nettype wire
